enemy_sprite_renderer: RTL
==========================

# enemy_sprite_renderer

Consumes position updates from an enemy datapath and turns each update into VGA pixel writes. On every update it erases the sprite at the previously drawn position with the background colour, then draws it at the new position. It sits between the enemy datapath (its `doneUpdate` pulse and coordinates) and the VGA adapter's pixel-plot port. Its output is one pixel per clock.

## Interface
Parameters:
- `SPRITE_W`, 4: sprite width in pixels (1–8).
- `SPRITE_H`, 4: sprite height in pixels (1–8).
- `BG_COLOUR`, 3'b000: colour used for erase.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-low reset.
- `space_pressed`  in  1: synchronous game restart. Aborts any scan, returns to IDLE, clears `have_old` and `pending`.
- `enemy_x`  in  8: new sprite top-left x.
- `enemy_y`  in  7: new sprite top-left y.
- `enemy_colour`  in  3: sprite colour.
- `enemy_done`  in  1: one-cycle pulse; coordinates are valid in the same cycle.
- `vga_x`  out  8: pixel x (registered).
- `vga_y`  out  7: pixel y (registered).
- `vga_colour`  out  3: pixel colour (registered).
- `vga_plot`  out  1: write strobe (registered).
- `busy`  out  1: high in any state other than IDLE.
- `draw_done`  out  1: one-cycle pulse when an update has been fully rendered.

## Operation
- States: IDLE, ERASE, DRAW, FINISH.
- Internal registers:
  - `old_x`/`old_y`: last drawn position.
  - `new_x`/`new_y`/`new_col`: captured update.
  - `have_old`: an old sprite is on screen.
  - `pending`, `pend_x`/`pend_y`/`pend_col`: one queued update.
  - `dx`, `dy`: scan counters.
- IDLE with `enemy_done`=1:
  - Capture the coordinates and colour.
  - Clear `dx` and `dy`.
  - Go to ERASE if `have_old`, else go to DRAW.
- ERASE:
  - Emit pixel (`old_x`+`dx`, `old_y`+`dy`) with `BG_COLOUR`.
  - Scan is row-major: `dx` increments fastest; on `dx`=`SPRITE_W`-1, `dx` returns to 0 and `dy` increments.
  - After pixel (`SPRITE_W`-1, `SPRITE_H`-1), clear the counters and go to DRAW.
- DRAW:
  - Same scan at (`new_x`, `new_y`) with `new_col`.
  - After the last pixel: `old_x`/`old_y` ← `new_x`/`new_y`, set `have_old`, go to FINISH.
- FINISH:
  - Assert `draw_done` for one cycle.
  - If `pending`, load the pending fields, clear `pending`, and go to ERASE.
  - Otherwise go to IDLE.
- `enemy_done` while not in IDLE:
  - Overwrite the pending fields and set `pending`. Only the latest update is kept, so intermediate positions are dropped.
  - A pulse arriving in the FINISH cycle is also queued.
- Arithmetic and clipping:
  - Sums are computed at 9 bits (x) and 8 bits (y).
  - A pixel with sum x ≥ 160 or sum y ≥ 120 is clipped: `vga_plot`=0, and the counters still advance. No wrap-around in pixel space.
  - Example: the datapath wrap from x=0 to x=159 draws a 1-pixel-wide sliver at x=159 when `SPRITE_W`=4.
- `space_pressed` has priority over everything except `reset`.
- Reset values:
  - State IDLE.
  - `vga_x`=0, `vga_y`=0, `vga_colour`=0, `vga_plot`=0.
  - `busy`=0, `draw_done`=0.
  - `have_old`=0, `pending`=0, all coordinate registers 0.
- Reset applied mid-scan forces all of the above immediately (asynchronous). A partially drawn sprite is left on screen and is not tracked.

## Timing
- `enemy_done` is sampled at edge k.
- The first pixel's outputs are valid after edge k+1.
- Each pixel occupies exactly one cycle, with no gaps.
- With erase: ERASE pixels after edges k+1..k+N, DRAW pixels after k+N+1..k+2N, where N=`SPRITE_W`·`SPRITE_H`. `draw_done` is high after edge k+2N+1.
- Without erase (first update after reset or restart): `draw_done` is high after edge k+N+1.
- `busy` rises after edge k and falls after the FINISH cycle, unless a pending update chains directly into ERASE.
- Back-to-back updates can be serviced every 2N+1 cycles. This is far below the datapath's 250000-cycle step period.

## Structure
- Shared package `game_pkg` holds:
  - `SCREEN_W`=160 and `SCREEN_H`=120.
  - 3-bit colour constants (`COL_BLACK`, `COL_RED`, …).
  - Coordinate widths (8/7).
  - The state enum for this block.
- One sub-module: `sprite_scan_counter`.
  - Holds the `dx`/`dy` counters.
  - Inputs: `clear`, `enable`.
  - Outputs: `dx`, `dy`, `last`.
  - The FSM uses `last` to leave ERASE and DRAW.

## Test plan
- Reset, then `enemy_done` with (110,60), colour 3'b100 → 16 plots (110..113, 60..63) in red, row-major, no erase. `draw_done` after edge k+17.
- Second pulse with (109,60) → 16 black plots at (110..113, 60..63), then 16 red plots at (109..112, 60..63). `draw_done` after edge k+33.
- Pulse with x=159 → erase at the previous position, then only x=159 plotted for rows 60..63. The other 12 cycles have `vga_plot`=0. Total cycle count unchanged.
- Pulses at (100,60), then (99,60) and (98,60) while busy → only (98,60) is rendered after the first update. Two `draw_done` pulses, chained with no IDLE cycle.
- `space_pressed` during DRAW pixel 7 → `vga_plot`=0 next cycle, `busy`=0. The next pulse draws without erase.
- `reset` asserted asynchronously mid-ERASE → outputs are 0 before the next clock edge. Behaviour matches the first scenario afterward.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: screen geometry, coordinate widths, colour
// constants and the enemy sprite renderer state encoding.
package game_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;

   localparam int X_W    = 8;
   localparam int Y_W    = 7;
   localparam int COL_W  = 3;
   // Sprite dimensions are limited to 8, so scan counters fit in 3 bits.
   localparam int SCAN_W = 3;

   localparam logic [COL_W-1:0] COL_BLACK   = 3'b000;
   localparam logic [COL_W-1:0] COL_BLUE    = 3'b001;
   localparam logic [COL_W-1:0] COL_GREEN   = 3'b010;
   localparam logic [COL_W-1:0] COL_CYAN    = 3'b011;
   localparam logic [COL_W-1:0] COL_RED     = 3'b100;
   localparam logic [COL_W-1:0] COL_MAGENTA = 3'b101;
   localparam logic [COL_W-1:0] COL_YELLOW  = 3'b110;
   localparam logic [COL_W-1:0] COL_WHITE   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ERASE  = 2'd1,
      ST_DRAW   = 2'd2,
      ST_FINISH = 2'd3
   } render_state_t;

   // Pixel sums are one bit wider than the screen coordinates so that a
   // sprite hanging off the right or bottom edge is clipped, not wrapped.
   function automatic logic on_screen(input logic [X_W:0] sum_x,
                                      input logic [Y_W:0] sum_y);
      return (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
   endfunction

endpackage

// File: rtl/enemy_sprite_renderer_if.sv
// Bundle between the enemy datapath (position updates), the renderer and
// the VGA adapter pixel-plot port.
//
// Handshake: enemy_done is a single-cycle valid pulse with no ready; the
// coordinates and colour are only meaningful in the cycle enemy_done is high.
// The renderer always accepts: an update arriving while it is busy replaces
// any earlier queued update. vga_plot is a write strobe, one pixel per cycle,
// and vga_x/vga_y/vga_colour are valid whenever vga_plot is high.
interface enemy_sprite_renderer_if;
   import game_pkg::*;

   logic [X_W-1:0]   enemy_x;
   logic [Y_W-1:0]   enemy_y;
   logic [COL_W-1:0] enemy_colour;
   logic             enemy_done;

   logic [X_W-1:0]   vga_x;
   logic [Y_W-1:0]   vga_y;
   logic [COL_W-1:0] vga_colour;
   logic             vga_plot;
   logic             busy;
   logic             draw_done;

   // Datapath / environment side.
   modport master (
      output enemy_x, enemy_y, enemy_colour, enemy_done,
      input  vga_x, vga_y, vga_colour, vga_plot, busy, draw_done
   );

   // Renderer side.
   modport slave (
      input  enemy_x, enemy_y, enemy_colour, enemy_done,
      output vga_x, vga_y, vga_colour, vga_plot, busy, draw_done
   );

endinterface

// File: rtl/sprite_scan_counter.sv
// Row-major scan over a SPRITE_W x SPRITE_H box: dx advances every enabled
// cycle, dy advances when dx wraps. last flags the final pixel of the box.
module sprite_scan_counter
   import game_pkg::*;
#(
   parameter int SPRITE_W = 4,
   parameter int SPRITE_H = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   output logic [SCAN_W-1:0] dx,
   output logic [SCAN_W-1:0] dy,
   output logic              last
);

   localparam logic [SCAN_W-1:0] DX_LAST = SCAN_W'(SPRITE_W - 1);
   localparam logic [SCAN_W-1:0] DY_LAST = SCAN_W'(SPRITE_H - 1);

   // Final pixel of the box.
   assign last = (dx == DX_LAST) && (dy == DY_LAST);

   // Scan counters; clear wins over enable so the FSM can restart a scan.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dx <= '0;
         dy <= '0;
      end else if (clear) begin
         dx <= '0;
         dy <= '0;
      end else if (enable) begin
         if (dx == DX_LAST) begin
            dx <= '0;
            dy <= dy + 1'b1;
         end else begin
            dx <= dx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/enemy_sprite_renderer.sv
// Turns enemy position updates into VGA pixel writes: erase the sprite at
// its previous position with the background colour, then draw it at the new
// one. One registered pixel per clock; a single update may be queued while
// a render is in progress (latest update wins).
module enemy_sprite_renderer
   import game_pkg::*;
#(
   parameter int               SPRITE_W  = 4,
   parameter int               SPRITE_H  = 4,
   parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   space_pressed,
   enemy_sprite_renderer_if.slave bus,
   output render_state_t          dbg_state
);

   render_state_t    state, state_d;

   logic [X_W-1:0]   old_x, new_x, pend_x;
   logic [Y_W-1:0]   old_y, new_y, pend_y;
   logic [COL_W-1:0] new_col, pend_col;
   logic             have_old;
   logic             pending;

   logic [SCAN_W-1:0] dx, dy;
   logic              scan_last;
   logic              scan_clear;
   logic              scan_en;

   logic              scanning;
   logic [X_W-1:0]    base_x;
   logic [Y_W-1:0]    base_y;
   logic [X_W:0]      sum_x;
   logic [Y_W:0]      sum_y;
   logic              in_view;

   sprite_scan_counter #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H)
   ) u_scan (
      .clk    (clk),
      .reset  (reset),
      .clear  (scan_clear),
      .enable (scan_en),
      .dx     (dx),
      .dy     (dy),
      .last   (scan_last)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state and scan-counter control; restart overrides everything.
   always_comb begin
      state_d    = state;
      scan_clear = 1'b0;
      scan_en    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.enemy_done) begin
               scan_clear = 1'b1;
               state_d    = have_old ? ST_ERASE : ST_DRAW;
            end
         end
         ST_ERASE: begin
            scan_en = 1'b1;
            if (scan_last) begin
               scan_clear = 1'b1;
               state_d    = ST_DRAW;
            end
         end
         ST_DRAW: begin
            scan_en = 1'b1;
            if (scan_last) begin
               scan_clear = 1'b1;
               state_d    = ST_FINISH;
            end
         end
         ST_FINISH: begin
            // A pulse landing in this cycle counts as queued and is the
            // newest update, so it chains straight into the next render.
            if (pending || bus.enemy_done) begin
               scan_clear = 1'b1;
               state_d    = ST_ERASE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (space_pressed) begin
         scan_clear = 1'b1;
         state_d    = ST_IDLE;
      end
   end

   // Current pixel address and its clip test.
   always_comb begin
      scanning = (state == ST_ERASE) || (state == ST_DRAW);
      base_x   = (state == ST_ERASE) ? old_x : new_x;
      base_y   = (state == ST_ERASE) ? old_y : new_y;
      sum_x    = {1'b0, base_x} + {{(X_W+1-SCAN_W){1'b0}}, dx};
      sum_y    = {1'b0, base_y} + {{(Y_W+1-SCAN_W){1'b0}}, dy};
      in_view  = on_screen(sum_x, sum_y);
   end

   // Position bookkeeping, update queue and registered pixel outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         old_x          <= '0;
         old_y          <= '0;
         new_x          <= '0;
         new_y          <= '0;
         new_col        <= '0;
         pend_x         <= '0;
         pend_y         <= '0;
         pend_col       <= '0;
         have_old       <= 1'b0;
         pending        <= 1'b0;
         bus.vga_x      <= '0;
         bus.vga_y      <= '0;
         bus.vga_colour <= '0;
         bus.vga_plot   <= 1'b0;
         bus.draw_done  <= 1'b0;
      end else if (space_pressed) begin
         // Game restart: forget the on-screen sprite and any queued update.
         have_old      <= 1'b0;
         pending       <= 1'b0;
         bus.vga_plot  <= 1'b0;
         bus.draw_done <= 1'b0;
      end else begin
         bus.vga_plot  <= scanning && in_view;
         bus.draw_done <= (state == ST_FINISH);
         if (scanning) begin
            bus.vga_x      <= sum_x[X_W-1:0];
            bus.vga_y      <= sum_y[Y_W-1:0];
            bus.vga_colour <= (state == ST_ERASE) ? BG_COLOUR : new_col;
         end
         unique case (state)
            ST_IDLE: begin
               if (bus.enemy_done) begin
                  new_x   <= bus.enemy_x;
                  new_y   <= bus.enemy_y;
                  new_col <= bus.enemy_colour;
               end
            end
            ST_DRAW: begin
               if (scan_last) begin
                  old_x    <= new_x;
                  old_y    <= new_y;
                  have_old <= 1'b1;
               end
            end
            ST_FINISH: begin
               pending <= 1'b0;
               if (bus.enemy_done) begin
                  new_x   <= bus.enemy_x;
                  new_y   <= bus.enemy_y;
                  new_col <= bus.enemy_colour;
               end else if (pending) begin
                  new_x   <= pend_x;
                  new_y   <= pend_y;
                  new_col <= pend_col;
               end
            end
            default: ;
         endcase
         // Updates during a scan overwrite the single queue slot.
         if (bus.enemy_done && scanning) begin
            pend_x   <= bus.enemy_x;
            pend_y   <= bus.enemy_y;
            pend_col <= bus.enemy_colour;
            pending  <= 1'b1;
         end
      end
   end

   assign bus.busy  = (state != ST_IDLE);
   assign dbg_state = state;

endmodule
